bip_control_sequencer: RTL and testbench
========================================

Name: bip_control_sequencer

Overview:
Parametrised control unit for the BIP-style accumulator CPU: sequences the program counter, decodes the fetched instruction into datapath controls, and tracks run/halt status. It extends the original 8-opcode decode with jump and conditional branches, a start/halt FSM, stall handshake, illegal-opcode trap and an instruction counter. It sits between program memory (async read, addressed by o_pc) and the accumulator/ALU/data-RAM datapath.

Parameters:
OPCODE_W, 5, opcode field width (MSBs of instruction)
OPERAND_W, 11, operand/immediate field width (LSBs of instruction)
PC_W, 11, program counter width; PC wraps modulo 2^PC_W
CNT_W, 16, executed-instruction counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
i_instr  in  OPCODE_W+OPERAND_W  instruction at o_pc (same-cycle async read)
i_start  in  1  pulse: leave IDLE/HALT and run from PC 0
i_stall  in  1  datapath not ready; hold current instruction
i_acc_zero  in  1  accumulator == 0 flag
o_pc  out  PC_W  program memory address
o_operand  out  OPERAND_W  operand field of i_instr, passed through
o_sel_a  out  2  ACC input mux select
o_sel_b  out  1  ALU operand B select (0 RAM, 1 immediate)
o_wr_acc  out  1  accumulator write enable
o_op  out  1  ALU op (1 add, 0 sub)
o_wr_ram  out  1  data RAM write enable
o_rd_ram  out  1  data RAM read enable
o_halted  out  1  FSM in HALT
o_illegal  out  1  sticky: halted on illegal opcode
o_icount  out  CNT_W  instructions retired since last start

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, o_pc=0, o_icount=0, o_illegal=0, o_halted=0; all controls 0, o_sel_a=00.
- States: IDLE, RUN, HALT. IDLE: controls 0; i_start=1 -> RUN next cycle, o_pc=0.
- RUN: controls decoded combinationally from i_instr opcode (SelA,SelB,WrACC,Op,WrRAM,RdRAM):
  HLT 00000: 00,0,0,0,0,0; next state HALT, PC holds.
  STO 00001: 00,1,0,0,1,0. LD 00010: 00,0,1,0,0,1. LDI 00011: 01,0,1,0,0,0.
  ADD 00100: 10,0,1,1,0,1. ADDI 00101: 10,1,1,1,0,0. SUB 00110: 10,0,1,0,0,1. SUBI 00111: 10,1,1,0,0,0.
  JMP 01000: all 0; PC <= operand[PC_W-1:0]. BEQ 01001: all 0; PC <= operand if i_acc_zero else PC+1. BNE 01010: all 0; PC <= operand if !i_acc_zero else PC+1.
  Other opcodes: SelA=11, rest 0; next state HALT, o_illegal<=1; PC holds.
- Non-branch retiring instructions: PC <= PC+1 (wrap 2^PC_W-1 -> 0).
- Operand wider/narrower than PC: truncate or zero-extend to PC_W.
- Stall: i_stall=1 in RUN -> o_wr_acc, o_wr_ram forced 0 (reads/selects still driven), PC, state, counter hold. Stall ignored in IDLE/HALT.
- o_icount increments once per retired instruction (RUN, no stall, including HLT and branches; not illegal); saturates at all ones.
- HALT: controls 0, o_halted=1; o_pc, o_icount, o_illegal hold. i_start=1 -> RUN, PC=0, o_icount=0, o_illegal=0.
- i_start in RUN: ignored.
- Reset mid-RUN overrides everything; takes effect at that edge.
- Latency: decode 0 cycles (combinational on i_instr); PC/state update 1 cycle.

Decomposition:
- Shared package bip_pkg: opcode localparams (HLT..BNE), SelA encodings (SEL_RAM=00, SEL_IMM=01, SEL_ALU=10, SEL_ILL=11), state encoding.
- Sub-module bip_opcode_decoder: pure combinational opcode -> control/branch/halt/illegal flags; sequencer instantiates it and applies state/stall gating.

Test Plan:
- Reset then i_start; program LDI 5, ADDI 3, STO 7, HLT -> controls match table per cycle, o_pc 0,1,2,3 then hold 3, o_halted=1, o_icount=4.
- BEQ 10 with i_acc_zero=1 -> next o_pc=10; same with i_acc_zero=0 -> o_pc=PC+1; BNE inverse; JMP 0x7FF -> o_pc=0x7FF, next sequential -> 0 (wrap).
- Opcode 11111 at PC 4 -> o_sel_a=11 that cycle, then HALT, o_illegal=1, o_pc=4, o_icount not incremented.
- i_stall=1 for 3 cycles on STO -> o_wr_ram=0, o_rd_ram/o_sel_b held, PC and o_icount frozen; release -> o_wr_ram=1 one cycle, PC+1.
- rst_n=0 mid-program -> next edge o_pc=0, IDLE, all outputs reset; i_start while halted -> PC 0, o_icount=0, o_illegal cleared.
- CNT_W=2, run 5-instruction loop -> o_icount saturates at 3.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, ACC-mux encodings,
// sequencer states and the decoded-control bundle.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'd0;
    localparam logic [4:0] OP_STO  = 5'd1;
    localparam logic [4:0] OP_LD   = 5'd2;
    localparam logic [4:0] OP_LDI  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SUBI = 5'd7;
    localparam logic [4:0] OP_JMP  = 5'd8;
    localparam logic [4:0] OP_BEQ  = 5'd9;
    localparam logic [4:0] OP_BNE  = 5'd10;

    localparam logic [1:0] SEL_RAM = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;
    localparam logic [1:0] SEL_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_JMP  = 2'b01,
        BR_BEQ  = 2'b10,
        BR_BNE  = 2'b11
    } branch_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       wr_acc;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic branch_taken(input branch_t br, input logic acc_zero);
        logic taken;
        case (br)
            BR_JMP:  taken = 1'b1;
            BR_BEQ:  taken = acc_zero;
            BR_BNE:  taken = !acc_zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/bip_opcode_decoder.sv
// Pure combinational opcode decode into datapath controls plus
// branch / halt / illegal classification; no state or stall awareness.
module bip_opcode_decoder
    import bip_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output branch_t             branch,
    output logic                halt,
    output logic                illegal
);

    // Opcode table: {sel_a, sel_b, wr_acc, op, wr_ram, rd_ram}
    always_comb begin
        ctrl    = CTRL_NOP;
        branch  = BR_NONE;
        halt    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPCODE_W'(OP_HLT):  halt = 1'b1;
            OPCODE_W'(OP_STO):  ctrl = '{SEL_RAM, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            OPCODE_W'(OP_LD):   ctrl = '{SEL_RAM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            OPCODE_W'(OP_LDI):  ctrl = '{SEL_IMM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            OPCODE_W'(OP_ADD):  ctrl = '{SEL_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            OPCODE_W'(OP_ADDI): ctrl = '{SEL_ALU, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            OPCODE_W'(OP_SUB):  ctrl = '{SEL_ALU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            OPCODE_W'(OP_SUBI): ctrl = '{SEL_ALU, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            OPCODE_W'(OP_JMP):  branch = BR_JMP;
            OPCODE_W'(OP_BEQ):  branch = BR_BEQ;
            OPCODE_W'(OP_BNE):  branch = BR_BNE;
            default: begin
                ctrl.sel_a = SEL_ILL;
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bip_control_sequencer.sv
// BIP accumulator-CPU control unit: PC sequencing with jumps/branches,
// IDLE/RUN/HALT control, stall hold, illegal-opcode trap and retire counter.
module bip_control_sequencer
    import bip_pkg::*;
#(
    parameter int OPCODE_W  = 5,
    parameter int OPERAND_W = 11,
    parameter int PC_W      = 11,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [OPCODE_W+OPERAND_W-1:0] i_instr,
    input  logic                          i_start,
    input  logic                          i_stall,
    input  logic                          i_acc_zero,
    output logic [PC_W-1:0]               o_pc,
    output logic [OPERAND_W-1:0]          o_operand,
    output logic [1:0]                    o_sel_a,
    output logic                          o_sel_b,
    output logic                          o_wr_acc,
    output logic                          o_op,
    output logic                          o_wr_ram,
    output logic                          o_rd_ram,
    output logic                          o_halted,
    output logic                          o_illegal,
    output logic [CNT_W-1:0]              o_icount
);

    localparam int INSTR_W = OPCODE_W + OPERAND_W;

    state_t              state_r;
    logic [PC_W-1:0]     pc_r;
    logic [CNT_W-1:0]    icount_r;
    logic                illegal_r;
    logic                halted_r;

    logic [OPCODE_W-1:0] opcode_s;
    ctrl_t               dec_ctrl_s;
    branch_t             dec_branch_s;
    logic                dec_halt_s;
    logic                dec_illegal_s;
    ctrl_t               ctrl_s;
    logic [PC_W-1:0]     pc_next_s;

    assign opcode_s  = i_instr[INSTR_W-1:OPERAND_W];
    assign o_operand = i_instr[OPERAND_W-1:0];

    bip_opcode_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
        .opcode  (opcode_s),
        .ctrl    (dec_ctrl_s),
        .branch  (dec_branch_s),
        .halt    (dec_halt_s),
        .illegal (dec_illegal_s)
    );

    // Controls are live only in RUN; a stall suppresses the two write strobes
    always_comb begin
        ctrl_s = CTRL_NOP;
        if (state_r == ST_RUN) begin
            ctrl_s = dec_ctrl_s;
            if (i_stall) begin
                ctrl_s.wr_acc = 1'b0;
                ctrl_s.wr_ram = 1'b0;
            end else begin
                ctrl_s.wr_acc = dec_ctrl_s.wr_acc;
                ctrl_s.wr_ram = dec_ctrl_s.wr_ram;
            end
        end else begin
            ctrl_s = CTRL_NOP;
        end
    end

    // Next sequential PC or branch target (operand resized to PC width)
    always_comb begin
        pc_next_s = pc_r + PC_W'(1);
        if (branch_taken(dec_branch_s, i_acc_zero)) begin
            pc_next_s = PC_W'(o_operand);
        end else begin
            pc_next_s = pc_r + PC_W'(1);
        end
    end

    // Run/halt FSM with PC, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= '0;
            icount_r  <= '0;
            illegal_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALT: begin
                    if (i_start) begin
                        state_r   <= ST_RUN;
                        pc_r      <= '0;
                        icount_r  <= '0;
                        illegal_r <= 1'b0;
                        halted_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!i_stall) begin
                        if (dec_illegal_s) begin
                            state_r   <= ST_HALT;
                            halted_r  <= 1'b1;
                            illegal_r <= 1'b1;
                        end else begin
                            if (!(&icount_r)) begin
                                icount_r <= icount_r + CNT_W'(1);
                            end
                            if (dec_halt_s) begin
                                state_r  <= ST_HALT;
                                halted_r <= 1'b1;
                            end else begin
                                pc_r <= pc_next_s;
                            end
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc      = pc_r;
    assign o_icount  = icount_r;
    assign o_illegal = illegal_r;
    assign o_halted  = halted_r;
    assign o_sel_a   = ctrl_s.sel_a;
    assign o_sel_b   = ctrl_s.sel_b;
    assign o_wr_acc  = ctrl_s.wr_acc;
    assign o_op      = ctrl_s.op;
    assign o_wr_ram  = ctrl_s.wr_ram;
    assign o_rd_ram  = ctrl_s.rd_ram;

endmodule

// File: tb/tb_bip_control_sequencer.sv
// Randomised and directed bench for bip_control_sequencer against a
// behavioural model of the instruction-set rules.
module tb_bip_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        acc_zero = 1'b0;
    logic [15:0] instr;
    logic [10:0] pc, operand;
    logic [1:0]  sel_a;
    logic        sel_b, wr_acc, alu_op, wr_ram, rd_ram, halted, illegal;
    logic [15:0] icount;

    logic        start2 = 1'b0;
    logic        stall2 = 1'b0;
    logic        acc_zero2 = 1'b0;
    logic [15:0] instr2;
    logic [10:0] pc2, operand2;
    logic [1:0]  sel_a2;
    logic        sel_b2, wr_acc2, alu_op2, wr_ram2, rd_ram2, halted2, illegal2;
    logic [1:0]  icount2;

    logic [15:0] mem  [0:2047];
    logic [15:0] mem2 [0:2047];

    // {sel_a, sel_b, wr_acc, op, wr_ram, rd_ram} for opcodes 0..10
    logic [6:0] ctrl_tbl [0:10] = '{7'b00_0_0_0_0_0, 7'b00_1_0_0_1_0, 7'b00_0_1_0_0_1,
                                    7'b01_0_1_0_0_0, 7'b10_0_1_1_0_1, 7'b10_1_1_1_0_0,
                                    7'b10_0_1_0_0_1, 7'b10_1_1_0_0_0, 7'b00_0_0_0_0_0,
                                    7'b00_0_0_0_0_0, 7'b00_0_0_0_0_0};

    int n_checks = 0;
    int n_errors = 0;

    bit m_run, m_halt, m_ill;
    int m_pc, m_icnt;

    always #5 clk = ~clk;

    assign instr  = mem[pc];
    assign instr2 = mem2[pc2];

    bip_control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_instr(instr), .i_start(start), .i_stall(stall),
        .i_acc_zero(acc_zero), .o_pc(pc), .o_operand(operand), .o_sel_a(sel_a),
        .o_sel_b(sel_b), .o_wr_acc(wr_acc), .o_op(alu_op), .o_wr_ram(wr_ram),
        .o_rd_ram(rd_ram), .o_halted(halted), .o_illegal(illegal), .o_icount(icount)
    );

    bip_control_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_instr(instr2), .i_start(start2), .i_stall(stall2),
        .i_acc_zero(acc_zero2), .o_pc(pc2), .o_operand(operand2), .o_sel_a(sel_a2),
        .o_sel_b(sel_b2), .o_wr_acc(wr_acc2), .o_op(alu_op2), .o_wr_ram(wr_ram2),
        .o_rd_ram(rd_ram2), .o_halted(halted2), .o_illegal(illegal2), .o_icount(icount2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input int opc, input int opd);
        logic [4:0]  o;
        logic [10:0] d;
        o = opc[4:0];
        d = opd[10:0];
        return {o, d};
    endfunction

    function automatic logic [15:0] rand_ins();
        int r;
        int opc;
        r = $urandom_range(0, 99);
        if (r < 5)       opc = 0;
        else if (r < 10) opc = $urandom_range(11, 31);
        else             opc = $urandom_range(1, 10);
        return ins(opc, $urandom_range(0, 2047));
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    task automatic drive(input logic r, input logic s, input logic st, input logic az);
        @(negedge clk);
        rst_n = r; start = s; stall = st; acc_zero = az;
        #1;
    endtask

    // Compare every output with the model, then advance the model by one edge
    task automatic model_cycle();
        logic [15:0] w;
        int          opc, opd;
        logic [6:0]  exp;
        w   = mem[m_pc];
        opc = int'(w[15:11]);
        opd = int'(w[10:0]);
        exp = 7'd0;
        if (m_run) begin
            exp = (opc <= 10) ? ctrl_tbl[opc] : 7'b11_0_0_0_0_0;
            if (stall) begin
                exp[3] = 1'b0;
                exp[1] = 1'b0;
            end
        end
        check_eq("pc", pc, m_pc);
        check_eq("ctrl", {sel_a, sel_b, wr_acc, alu_op, wr_ram, rd_ram}, exp);
        check_eq("operand", operand, opd);
        check_eq("halted", halted, m_halt);
        check_eq("illegal", illegal, m_ill);
        check_eq("icount", icount, m_icnt);

        if (!rst_n) begin
            m_run = 0; m_halt = 0; m_ill = 0; m_pc = 0; m_icnt = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_halt = 0; m_ill = 0; m_pc = 0; m_icnt = 0;
            end
        end else if (!stall) begin
            if (opc > 10) begin
                m_run = 0; m_halt = 1; m_ill = 1;
            end else begin
                if (m_icnt < 65535) m_icnt++;
                if (opc == 0) begin
                    m_run = 0; m_halt = 1;
                end else if (opc == 8 || (opc == 9 && acc_zero) || (opc == 10 && !acc_zero)) begin
                    m_pc = opd;
                end else begin
                    m_pc = (m_pc + 1) % 2048;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic s, input logic st, input logic az);
        drive(r, s, st, az);
        model_cycle();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem2[i] = 16'h0000;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        m_run = 0; m_halt = 0; m_ill = 0; m_pc = 0; m_icnt = 0;

        // Reset state and the straight-line program LDI 5, ADDI 3, STO 7, HLT
        mem[0] = ins(3, 5); mem[1] = ins(5, 3); mem[2] = ins(1, 7); mem[3] = ins(0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_icount", icount, 0);
        check_eq("rst_halted", halted, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("ldi_sel_a", sel_a, 2'b01);
        check_eq("ldi_wr_acc", wr_acc, 1'b1);
        model_cycle();
        tick();
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("hlt_pc", pc, 3);
        check_eq("hlt_halted", halted, 1'b1);
        check_eq("hlt_icount", icount, 4);

        // Branches, jump with PC wrap, then an illegal opcode at PC 4
        clear_mem();
        mem[0] = ins(9, 10);  mem[10] = ins(9, 20); mem[11] = ins(10, 30);
        mem[30] = ins(10, 40); mem[31] = ins(8, 2047); mem[2047] = ins(5, 1);
        mem[1] = ins(3, 2); mem[2] = ins(4, 0); mem[3] = ins(6, 0); mem[4] = ins(31, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("beq_taken", pc, 10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("beq_fall", pc, 11);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("bne_taken", pc, 30);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("bne_fall", pc, 31);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("jmp_max", pc, 11'h7FF);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pc_wrap", pc, 0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("ill_sel_a", sel_a, 2'b11);
        model_cycle();
        tick();
        check_eq("ill_flag", illegal, 1'b1);
        check_eq("ill_pc", pc, 4);
        check_eq("ill_icount", icount, 10);

        // Restart from HALT, then stall a STO for three cycles
        clear_mem();
        mem[0] = ins(1, 7); mem[1] = ins(0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("restart_ill", illegal, 1'b0);
        check_eq("restart_icount", icount, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            check_eq("stall_wr_ram", wr_ram, 1'b0);
            check_eq("stall_sel_b", sel_b, 1'b1);
            model_cycle();
            tick();
            check_eq("stall_pc", pc, 0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("release_wr_ram", wr_ram, 1'b1);
        model_cycle();
        tick();
        check_eq("release_pc", pc, 1);
        check_eq("release_icount", icount, 1);

        // Reset in the middle of a running loop
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = ins(5, 1);
        mem[8] = ins(8, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("midrst_pc", pc, 0);
        check_eq("midrst_icount", icount, 0);
        check_eq("midrst_sel_a", sel_a, 2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Random programs with random start/stall/flag/reset activity
        for (int i = 0; i < 2048; i++) mem[i] = rand_ins();
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)));
        end

        // Two-bit counter saturates on a five-instruction loop
        mem2[0] = ins(3, 1); mem2[1] = ins(5, 1); mem2[2] = ins(5, 1);
        mem2[3] = ins(7, 1); mem2[4] = ins(8, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("sat_icount_2", icount2, 2);
        check_eq("sat_pc_2", pc2, 2);
        repeat (8) @(negedge clk);
        check_eq("sat_icount_max", icount2, 3);
        check_eq("sat_pc_loop", pc2, 0);
        check_eq("sat_running", halted2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
